rv32c_fetch_realign: RTL and testbench
======================================

Name: rv32c_fetch_realign

Overview:
- Halfword realignment buffer sitting directly upstream of the RV32C decompressor.
- Accepts word-aligned 32-bit instruction-memory words and stores them as a halfword FIFO.
- Emits one instruction per handshake: either a 16-bit compressed parcel (zero-extended) or a 32-bit instruction that may straddle two fetch words.
- Each output carries its PC and a compressed flag; the decompressor expands compressed parcels downstream.

Parameters:
HW_DEPTH, 4, halfword FIFO capacity; power of two, minimum 4.
RESET_PC, 32'h0000_0200, PC after reset; bit 0 must be 0.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
flush  input  1  redirect request; discards all buffered state
flush_pc  input  32  redirect target; halfword-aligned
fetch_addr  output  32  word-aligned address of the next word to fetch
fetch_req  output  1  buffer can accept a word this cycle
fetch_valid  input  1  fetch_word is valid for fetch_addr this cycle
fetch_word  input  32  instruction-memory data; little-endian halfwords
out_valid  output  1  out_inst/out_pc/out_compressed valid
out_ready  input  1  downstream consumes the instruction
out_inst  output  32  instruction; compressed parcels are {16'h0, hw}
out_pc  output  32  PC of out_inst
out_compressed  output  1  head parcel has [1:0] != 2'b11

Behaviour:
- Reset (nrst low, asynchronous):
  - count = 0; head and tail pointers = 0.
  - pc = RESET_PC; fetch_addr = {RESET_PC[31:2], 2'b00}; drop_low = RESET_PC[1].
  - out_valid = 0; fetch_req = 1; out_inst/out_pc reflect internal state but are qualified by out_valid.
- Word accept:
  - fetch_req = !flush && (count <= HW_DEPTH-2). Decided on registered count only; same-cycle dequeue is not credited.
  - Accept when fetch_req && fetch_valid:
    - drop_low = 0: enqueue fetch_word[15:0] then fetch_word[31:16]; count += 2.
    - drop_low = 1: enqueue fetch_word[31:16] only; count += 1; clear drop_low.
  - On accept, fetch_addr += 4 (wraps modulo 2^32).
- Output:
  - Head halfword h0, next h1.
  - out_compressed = (h0[1:0] != 2'b11).
  - out_valid = !flush && ((count >= 1 && out_compressed) || (count >= 2 && !out_compressed)).
  - A 32-bit instruction with count = 1 stalls (out_valid = 0) until the next word arrives.
  - out_inst = out_compressed ? {16'h0, h0} : {h1, h0}; out_pc = pc.
  - Outputs are combinational from registered state: zero-cycle latency once the parcels are present. A first word fetched after reset or flush appears on out_* the cycle after it is accepted.
- Handshake:
  - On out_valid && out_ready: pop 1 halfword (compressed) or 2 (32-bit); pc += 2 or 4.
  - out_* are held stable while out_valid && !out_ready.
- Simultaneous accept and pop in one cycle: count_next = count + pushed − popped; the pointers wrap modulo HW_DEPTH.
- Flush (synchronous, highest priority):
  - A same-cycle fetch word and same-cycle pop are both ignored; out_valid and fetch_req are forced 0.
  - Next state: count = 0; pc = flush_pc; fetch_addr = {flush_pc[31:2], 2'b00}; drop_low = flush_pc[1].
- Invariants: count never exceeds HW_DEPTH and never goes below 0. An out_ready with out_valid = 0 has no effect.

Optional Feature:
RV32C_FETCH_PERF_EN
- Defined: adds output ports perf_cinst_cnt[31:0] and perf_split_stall_cnt[31:0], both reset to 0 and wrapping.
  - perf_cinst_cnt increments on each compressed handshake.
  - perf_split_stall_cnt increments each cycle with count == 1, h0[1:0] == 2'b11 and !flush.
  - Flush does not clear either counter.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC = 0x200, then fetch_word 0x4501_4581 (c.li a1,0 / c.li a0,0):
  - fetch_addr = 0x200.
  - Two outputs: {0x0000_4581} @0x200 compressed, then {0x0000_4501} @0x202 compressed.
  - fetch_addr = 0x204.
- Straddle: words 0x0093_4581 then 0x4501_0000 (32-bit addi x1,x0,0 spanning halves):
  - Outputs: 0x4581 @0x200; 0x0000_0093 @0x202 with out_compressed = 0, valid only after the second word; then 0x4501 @0x206.
- Flush to flush_pc = 0x1002, with word 0xABCD_4505 returned at fetch_addr 0x1000:
  - Low half dropped; single output 0xABCD would be 32-bit only if [1:0] = 11.
  - 0xABCD[1:0] = 01, so output {16'h0, 0xABCD} @0x1002, compressed.
- Backpressure: out_ready = 0 with the FIFO full (count = 4):
  - fetch_req = 0; out_* stable.
  - On out_ready = 1, pops proceed and fetch_req reasserts when count <= 2.
- Flush in the same cycle as fetch_valid and out_ready:
  - No pop and no push; the next cycle shows count = 0 and pc = flush_pc.
  - A subsequent nrst pulse mid-stream restores fetch_addr = 0x200 asynchronously.
- With RV32C_FETCH_PERF_EN, running the straddle test: perf_cinst_cnt = 2 and perf_split_stall_cnt ≥ 1.

Source files
------------

// File: rtl/rv32c_fetch_realign.sv
// Halfword realignment FIFO feeding the RV32C decompressor: word fetches in, one 16/32-bit instruction out.
// Optional performance counters are compiled in with `define RV32C_FETCH_PERF_EN.
module rv32c_fetch_realign #(
    parameter int unsigned HW_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_compressed
`ifdef RV32C_FETCH_PERF_EN
    ,
    output logic [31:0] perf_cinst_cnt,
    output logic [31:0] perf_split_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(HW_DEPTH);
    localparam int unsigned CNT_W = $clog2(HW_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [15:0] mem_q [HW_DEPTH];
    logic [15:0] mem_d [HW_DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        drop_low_q, drop_low_d;

    logic [15:0] h0, h1;
    logic        accept, pop;
    cnt_t        push_n, pop_n;

    always_comb begin
        h0             = mem_q[head_q];
        h1             = mem_q[head_q + ptr_t'(1)];
        out_compressed = (h0[1:0] != 2'b11);
        out_valid      = !flush && ((count_q >= cnt_t'(1) && out_compressed) ||
                                    (count_q >= cnt_t'(2) && !out_compressed));
        // Credit is based on the registered count only, so a same-cycle pop never frees space early.
        fetch_req      = !flush && (count_q <= cnt_t'(HW_DEPTH - 2));
        out_inst       = out_compressed ? {16'h0000, h0} : {h1, h0};
        out_pc         = pc_q;
        fetch_addr     = fetch_addr_q;

        accept = fetch_req && fetch_valid;
        pop    = out_valid && out_ready;
        push_n = accept ? (drop_low_q ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0);
        pop_n  = pop ? (out_compressed ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0);
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_low_d   = drop_low_q;

        if (flush) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            pc_d         = flush_pc;
            fetch_addr_d = {flush_pc[31:2], 2'b00};
            drop_low_d   = flush_pc[1];
        end else begin
            if (accept) begin
                if (drop_low_q) begin
                    mem_d[tail_q] = fetch_word[31:16];
                    tail_d        = tail_q + ptr_t'(1);
                end else begin
                    mem_d[tail_q]              = fetch_word[15:0];
                    mem_d[tail_q + ptr_t'(1)]  = fetch_word[31:16];
                    tail_d                     = tail_q + ptr_t'(2);
                end
                fetch_addr_d = fetch_addr_q + 32'd4;
                drop_low_d   = 1'b0;
            end
            if (pop) begin
                head_d = head_q + (out_compressed ? ptr_t'(1) : ptr_t'(2));
                pc_d   = pc_q + (out_compressed ? 32'd2 : 32'd4);
            end
            count_d = count_q + push_n - pop_n;
        end
    end

    // NOTE: the parcel storage has no reset; count qualifies every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            drop_low_q   <= RESET_PC[1];
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_low_q   <= drop_low_d;
        end
    end

`ifdef RV32C_FETCH_PERF_EN
    logic [31:0] perf_cinst_q, perf_cinst_d;
    logic [31:0] perf_split_q, perf_split_d;

    always_comb begin
        perf_cinst_d = perf_cinst_q + 32'(pop && out_compressed);
        // A lone upper half of a 32-bit instruction waiting for its second word.
        perf_split_d = perf_split_q + 32'((count_q == cnt_t'(1)) && (h0[1:0] == 2'b11) && !flush);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_cinst_q <= '0;
            perf_split_q <= '0;
        end else begin
            perf_cinst_q <= perf_cinst_d;
            perf_split_q <= perf_split_d;
        end
    end

    assign perf_cinst_cnt       = perf_cinst_q;
    assign perf_split_stall_cnt = perf_split_q;
`endif

endmodule

// File: tb/tb_rv32c_fetch_realign.sv
// Self-checking bench for rv32c_fetch_realign: directed scenarios plus random traffic against
// an address-level model (instruction stream read straight from a memory image by PC).
module tb_rv32c_fetch_realign;

    localparam int          D        = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_compressed;
`ifdef RV32C_FETCH_PERF_EN
    logic [31:0] perf_cinst_cnt;
    logic [31:0] perf_split_stall_cnt;
`endif

    rv32c_fetch_realign #(.HW_DEPTH(D), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .fetch_addr     (fetch_addr),
        .fetch_req      (fetch_req),
        .fetch_valid    (fetch_valid),
        .fetch_word     (fetch_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_compressed (out_compressed)
`ifdef RV32C_FETCH_PERF_EN
        ,
        .perf_cinst_cnt       (perf_cinst_cnt),
        .perf_split_stall_cnt (perf_split_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory image: directed overrides, otherwise a fixed hash of the address.
    logic [31:0] ovr [logic [31:0]];

    function automatic logic [31:0] img(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = img({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Model: next instruction PC and fetch frontier; buffered halfwords = (frontier - pc) / 2.
    logic [31:0] m_pc, m_faddr;
    int          m_cinst, m_split;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
    } rec_t;
    rec_t hist[$];

    task automatic model_reset();
        m_pc    = RST_PC;
        m_faddr = {RST_PC[31:2], 2'b00};
        m_cinst = 0;
        m_split = 0;
    endtask

    // Called at a negedge: drive inputs, check outputs, advance the model, move to the next negedge.
    task automatic step(input bit fl, input logic [31:0] fpc, input bit fv, input bit rdy);
        int          bufhw;
        logic [15:0] hw0;
        logic        comp, exp_fr, exp_ov;
        logic [31:0] exp_inst;
        flush       = fl;
        flush_pc    = fpc;
        fetch_valid = fv;
        out_ready   = rdy;
        fetch_word  = img(fetch_addr);
        #1;
        bufhw    = int'(m_faddr - m_pc) / 2;
        hw0      = half(m_pc);
        comp     = (hw0[1:0] != 2'b11);
        exp_inst = comp ? {16'h0000, hw0} : {half(m_pc + 32'd2), hw0};
        exp_fr   = !fl && (bufhw <= D - 2);
        exp_ov   = !fl && ((bufhw >= 1 && comp) || (bufhw >= 2 && !comp));
        check("fetch_addr", fetch_addr, m_faddr);
        check("fetch_req", 32'(fetch_req), 32'(exp_fr));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", out_pc, m_pc);
            check("out_inst", out_inst, exp_inst);
            check("out_compressed", 32'(out_compressed), 32'(comp));
        end
        if (!fl && bufhw == 1 && !comp) m_split++;
        if (fl) begin
            m_pc    = fpc;
            m_faddr = {fpc[31:2], 2'b00};
        end else begin
            if (exp_fr && fv) m_faddr = m_faddr + 32'd4;
            if (exp_ov && rdy) begin
                hist.push_back('{m_pc, exp_inst, comp});
                if (comp) m_cinst++;
                m_pc = m_pc + (comp ? 32'd2 : 32'd4);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_fetch_addr", fetch_addr, 32'h0000_0200);
        check("rst_fetch_req", 32'(fetch_req), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        hist.delete();
    endtask

    task automatic check_rec(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] inst, input logic comp);
        if (hist.size() > idx) begin
            check({tag, "_pc"}, hist[idx].pc, pc);
            check({tag, "_inst"}, hist[idx].inst, inst);
            check({tag, "_comp"}, 32'(hist[idx].comp), 32'(comp));
        end else begin
            check({tag, "_missing"}, 32'(hist.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Two compressed parcels in one word.
        ovr[32'h0000_0200] = 32'h4501_4581;
        do_reset();
        step(0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        check_rec("t1_a", 0, 32'h0000_0200, 32'h0000_4581, 1'b1);
        check_rec("t1_b", 1, 32'h0000_0202, 32'h0000_4501, 1'b1);

        // 32-bit instruction straddling two words; second word held back to force a stall.
        ovr[32'h0000_0200] = 32'h0093_4581;
        ovr[32'h0000_0204] = 32'h4501_0000;
        do_reset();
        step(0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        check("straddle_stall", 32'(out_valid), 32'd0);
        step(0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        check_rec("t2_a", 0, 32'h0000_0200, 32'h0000_4581, 1'b1);
        check_rec("t2_b", 1, 32'h0000_0202, 32'h0000_0093, 1'b0);
        check_rec("t2_c", 2, 32'h0000_0206, 32'h0000_4501, 1'b1);
`ifdef RV32C_FETCH_PERF_EN
        check("perf_cinst", perf_cinst_cnt, 32'd2);
        check("perf_split_ge1", 32'(perf_split_stall_cnt >= 32'd1), 32'd1);
        check("perf_split", perf_split_stall_cnt, 32'(m_split));
`endif

        // Backpressure with a full buffer.
        do_reset();
        repeat (4) step(0, 0, 1, 0);
        #1;
        check("full_fetch_req", 32'(fetch_req), 32'd0);
        check("full_hold_inst", out_inst, 32'h0000_4581);
        repeat (3) step(0, 0, 1, 0);
        check("full_hold_inst2", out_inst, 32'h0000_4581);
        repeat (8) step(0, 0, 1, 1);

        // Flush colliding with a fetch and a pop, then redirect to an odd halfword.
        ovr[32'h0000_1000] = 32'hABCD_4505;
        do_reset();
        repeat (3) step(0, 0, 1, 1);
        hist.delete();
        step(1, 32'h0000_1002, 1, 1);
        check("flush_no_pop", 32'(hist.size()), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        check_rec("t4", 0, 32'h0000_1002, 32'h0000_ABCD, 1'b1);

        // Random traffic with occasional redirects, including ones near the top of memory.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fpc;
            bit fl;
            fl  = ($urandom_range(31) == 0);
            fpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : $urandom;
            fpc[0] = 1'b0;
            step(fl, fpc, $urandom_range(3) != 0, $urandom_range(3) != 0);
        end
`ifdef RV32C_FETCH_PERF_EN
        check("perf_cinst_rand", perf_cinst_cnt, 32'(m_cinst));
        check("perf_split_rand", perf_split_stall_cnt, 32'(m_split));
`endif

        // Asynchronous reset mid-stream, away from any clock edge.
        flush = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check("async_fetch_addr", fetch_addr, 32'h0000_0200);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_fetch_req", 32'(fetch_req), 32'd1);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) step(0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
